// File: rtl/ip6s_bist_pkg.sv
// Shared types and constants for the IP6S BIST driver/checker.
package ip6s_bist_pkg;

    localparam int LFSR_W = 6;
    localparam int MISR_W = 8;

    // Feedback taps for x^6+x^5+1 (bits 5 and 4); the sequence has period 63.
    localparam logic [LFSR_W-1:0] LFSR_TAP  = 6'b110000;
    localparam logic [MISR_W-1:0] MISR_POLY = 8'h71;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        APPLY = ST_APPLY,
        FLUSH = ST_FLUSH,
        DONE  = ST_DONE
    } state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAP)};
    endfunction

endpackage

// File: rtl/ip6s_misr.sv
// 8-bit Galois MISR: synchronous clear, compact when enabled, otherwise hold.
module ip6s_misr
    import ip6s_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [2:0]        din,
    output logic [MISR_W-1:0] sig
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= {sig[MISR_W-2:0], 1'b0}
                 ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                 ^ MISR_W'(din);
        end
    end

endmodule

// File: rtl/ip6s_bist_ctrl.sv
// BIST driver/checker for the IP6S benchmark: LFSR stimulus, MISR compaction, golden compare.
// Optional diagnostics (sig_out, fail_first) are built only when IP6S_BIST_DIAG_EN is defined.
module ip6s_bist_ctrl
    import ip6s_bist_pkg::*;
#(
    parameter int unsigned        N_PAT     = 64,
    parameter int unsigned        SKIP      = 3,
    parameter int unsigned        FLUSH_CYC = 3,
    parameter logic [LFSR_W-1:0]  SEED      = 6'h01,
    parameter logic [MISR_W-1:0]  GOLDEN    = 8'h00
) (
    input  logic              CK,
    input  logic              RN,
    input  logic              start,
    input  logic [2:0]        rsp_in,
    output logic [LFSR_W-1:0] pat_out,
    output logic              busy,
    output logic              done,
    output logic              pass
`ifdef IP6S_BIST_DIAG_EN
    ,
    output logic [MISR_W-1:0] sig_out,
    output logic [9:0]        fail_first
`endif
);

    localparam int CNT_W = $clog2(N_PAT + 1);
    localparam int FL_W  = $clog2(FLUSH_CYC + 1);

    state_e             state;
    logic [CNT_W-1:0]   pat_cnt;
    logic [FL_W-1:0]    flush_cnt;
    logic [LFSR_W-1:0]  lfsr;
    logic [MISR_W-1:0]  misr;
    logic               launch;
    logic               compact;

    // The first SKIP responses come from the benchmark's unreset flops and are masked.
    assign launch  = start && (state == IDLE || state == DONE);
    assign compact = (state == APPLY && pat_cnt >= CNT_W'(SKIP)) || state == FLUSH;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            lfsr      <= SEED;
            pat_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= APPLY;
                        lfsr    <= SEED;
                        pat_cnt <= '0;
                    end
                end
                APPLY: begin
                    lfsr    <= lfsr_next(lfsr);
                    pat_cnt <= pat_cnt + 1'b1;
                    if (pat_cnt == CNT_W'(N_PAT - 1)) begin
                        state     <= FLUSH;
                        flush_cnt <= '0;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == FL_W'(FLUSH_CYC - 1)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All status outputs are registered images of the current state, one cycle behind it.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            pat_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
        end else begin
            pat_out <= (state == APPLY) ? lfsr : '0;
            busy    <= (state == APPLY) || (state == FLUSH);
            done    <= (state == DONE);
            pass    <= (state == DONE) && (misr == GOLDEN);
        end
    end

    ip6s_misr u_misr (
        .clk   (CK),
        .rst_n (RN),
        .clr   (launch),
        .en    (compact),
        .din   (rsp_in),
        .sig   (misr)
    );

`ifdef IP6S_BIST_DIAG_EN
    assign sig_out = misr;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            fail_first <= 10'h3FF;
        end else if (launch) begin
            fail_first <= 10'h3FF;
        end else if (compact && rsp_in != '0 && fail_first == 10'h3FF) begin
            fail_first <= 10'(pat_cnt);
        end
    end
`endif

endmodule
